// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU UART transmit/receive path:
// frame FSM state encoding, default line constants, and a counter sizing helper.
package alu_uart_pkg;

  // Frame sequencing states, shared with the future receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default oversampling factor (baud ticks per bit) and line rate.
  localparam int SB_TICK_DEFAULT = 16;
  localparam int BAUD_DEFAULT    = 9600;

  // Bits needed for a counter holding 0..range-1, never less than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator: counts 0..DIV-1 and pulses tick on the DIV-1 count.
// While clr is high the counter is held at zero and no tick is produced, so the
// first tick after clr drops arrives exactly DIV clocks later.
module baud_tick_gen
  import alu_uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic btn_Reset,
  input  logic clr,
  output logic tick
);

  localparam int             W    = cnt_width(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: wrap at DIV-1, forced to zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (btn_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// UART transmitter for ALU results: 1 start bit, NBITS data bits LSB first,
// 1 stop bit, idle-high line. Every bit lasts SB_TICK baud ticks of DIV clocks.
//
// Request handshake: tx_start is a level, sampled only while in IDLE. The edge
// that sees tx_start=1 in IDLE accepts the request and latches din; requests
// seen in any other state are dropped, not queued. tx_busy is high from the
// cycle after the accepting edge until the edge that returns to IDLE, and
// tx_done_tick marks the final clock of the stop bit.
module alu_result_tx
  import alu_uart_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int SB_TICK  = SB_TICK_DEFAULT,
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = BAUD_DEFAULT
) (
  input  logic             clk,
  input  logic             btn_Reset,
  input  logic             tx_start,
  input  logic [NBITS-1:0] din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int DIV = CLK_FREQ / (BAUD * SB_TICK);

  generate
    if (DIV < 1) begin : g_div_check
      $error("alu_result_tx: CLK_FREQ/(BAUD*SB_TICK) must be at least 1");
    end
  endgenerate

  localparam int              SW     = cnt_width(SB_TICK);
  localparam int              NW     = cnt_width(NBITS);
  localparam logic [SW-1:0]   S_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST = NW'(NBITS - 1);

  uart_state_e      state_q, state_d;
  logic [SW-1:0]    s_cnt_q, s_cnt_d;
  logic [NW-1:0]    n_cnt_q, n_cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             bit_end;
  logic             done;

  // Divider is held cleared in IDLE so each frame starts on a fresh tick phase.
  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk       (clk),
    .btn_Reset (btn_Reset),
    .clr       (state_q == IDLE),
    .tick      (tick)
  );

  assign bit_end = tick && (s_cnt_q == S_LAST);

  // Next-state, counters, shift register and the registered line value.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shreg_d = din;
          s_cnt_d = '0;
          n_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          s_cnt_d = '0;
          n_cnt_d = '0;
          state_d = DATA;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          s_cnt_d = '0;
          shreg_d = shreg_q >> 1;
          if (n_cnt_q == N_LAST) begin
            state_d = STOP;
          end else begin
            n_cnt_d = n_cnt_q + 1'b1;
          end
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          s_cnt_d = '0;
          state_d = IDLE;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line register follows the state being entered, so tx changes in
    // the same cycle as the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (btn_Reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx with DIV=1 (16 clocks per bit, 160 clocks per frame).
module tb_alu_result_tx;

  localparam int NBITS      = 8;
  localparam int SB_TICK    = 16;
  localparam int CLK_FREQ   = 160;
  localparam int BAUD       = 10;
  localparam int BIT_CLKS   = SB_TICK * (CLK_FREQ / (BAUD * SB_TICK));
  localparam int FRAME_CLKS = (NBITS + 2) * BIT_CLKS;

  // ---------------- clock / reset / DUT ----------------
  logic             clk       = 1'b0;
  logic             btn_Reset = 1'b1;
  logic             tx_start  = 1'b0;
  logic [NBITS-1:0] din       = '0;
  logic             tx;
  logic             tx_busy;
  logic             tx_done_tick;

  always #5 clk = ~clk;

  alu_result_tx #(
    .NBITS    (NBITS),
    .SB_TICK  (SB_TICK),
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk          (clk),
    .btn_Reset    (btn_Reset),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  // ---------------- scoreboard ----------------
  int               chk = 0;
  int               err = 0;
  logic [NBITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A request is taken whenever the line is free; a frame occupies FRAME_CLKS
  // edges and the next request can be taken one edge after it ends.
  int cyc       = 0;
  int free_at   = 0;
  int frame_end = -1;
  bit abort_req = 1'b0;

  always @(posedge clk) begin
    if (btn_Reset) begin
      if (cyc < frame_end && exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        abort_req = 1'b1;
      end
      frame_end = -1;
      free_at   = cyc + 1;
    end else if (tx_start && cyc >= free_at) begin
      exp_q.push_back(din);
      frame_end = cyc + FRAME_CLKS;
      free_at   = cyc + FRAME_CLKS + 1;
    end
    cyc++;
  end

  // ---------------- line monitor ----------------
  bit       mon_en    = 1'b0;
  bit       in_frame  = 1'b0;
  int       k         = 0;
  logic [9:0] bits    = '0;
  int       nege      = 0;
  int       last_end  = -1000;
  int       last_gap  = -1;
  int       abort_cnt = 0;

  always @(negedge clk) begin
    nege++;
    if (abort_req) begin
      abort_req = 1'b0;
      in_frame  = 1'b0;
      abort_cnt++;
      check("abort_tx", tx, 1);
      check("abort_busy", tx_busy, 0);
      check("abort_done", tx_done_tick, 0);
    end else if (mon_en) begin
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          k        = 0;
          last_gap = nege - last_end;
          check("start_busy", tx_busy, 1);
          check("frame_expected", exp_q.size() > 0, 1);
        end else begin
          check("idle_done", tx_done_tick, 0);
        end
      end
      if (in_frame) begin
        if (k < FRAME_CLKS && (k % BIT_CLKS) == BIT_CLKS / 2) begin
          bits[k / BIT_CLKS] = tx;
        end
        if (k == FRAME_CLKS - 1) begin
          check("done_pulse", tx_done_tick, 1);
          check("busy_last", tx_busy, 1);
        end else if (k < FRAME_CLKS) begin
          check("early_done", tx_done_tick, 0);
        end
        if (k == FRAME_CLKS) begin
          check("end_tx", tx, 1);
          check("end_busy", tx_busy, 0);
          check("end_done", tx_done_tick, 0);
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          if (exp_q.size() > 0) begin
            check("data", bits[8:1], exp_q.pop_front());
          end
          in_frame = 1'b0;
          last_end = nege;
        end
        k++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [NBITS-1:0] b);
    @(negedge clk);
    din      = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    din      = NBITS'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, ok, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset held for three edges, then a quiet line.
    btn_Reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    btn_Reset = 1'b0;
    mon_en    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        check("quiet_tx", tx, 1);
        check("quiet_busy", tx_busy, 0);
      end
    end

    // Single frame.
    send(8'hA5);
    wait_idle("a5");

    // Request during a frame is ignored.
    send(8'h3C);
    repeat (38) @(negedge clk);
    din      = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle("ignored");

    // Back-to-back with tx_start held high.
    @(negedge clk);
    din      = 8'h00;
    tx_start = 1'b1;
    repeat (20) @(negedge clk);
    din = 8'h81;
    repeat (200) @(negedge clk);
    tx_start = 1'b0;
    wait_idle("b2b");
    check("b2b_gap", last_gap, 1);

    // Reset in the middle of a frame, then a clean frame.
    send(8'h55);
    repeat (68) @(negedge clk);
    btn_Reset = 1'b1;
    @(negedge clk);
    btn_Reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_seen", abort_cnt, 1);
    send(8'h55);
    wait_idle("after_rst");

    // Edge data.
    send(8'hFF);
    wait_idle("ff");
    send(8'h00);
    wait_idle("zero");

    // Random bytes with random idle gaps.
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(NBITS'($urandom_range(0, 255)));
      wait_idle("rand");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
